// File: rtl/irq_pending_ctrl.sv
// Interrupt collector: synchronizes eight IRQ lines and latches them into PENDING (edge or level per source).
// A slave on the datapath data bus; reads are combinational and have zero latency.
module irq_pending_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0100,
    parameter logic [7:0]  RESET_MODE   = 8'hFF,
    parameter logic [7:0]  RESET_ENABLE = 8'h00
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iIRQ,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic [7:0]  oPendingInterrupt,
    output logic        oIRQAny
);

    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_ENABLE  = 3'd1;
    localparam logic [2:0] OFF_MODE    = 3'd2;
    localparam logic [2:0] OFF_RAW     = 3'd3;
    localparam logic [2:0] OFF_SET     = 3'd4;
    localparam logic [2:0] OFF_OVERRUN = 3'd5;

    logic [7:0] irqSync1, irqSync2, irqPrev;
    logic [7:0] pending, enable, mode, overrun;
    logic [7:0] pendingNext, overrunNext;
    logic [7:0] edgeDet, setBits, clrPending, clrOverrun, wrByte;
    logic [2:0] offset;
    logic       sel, wrEn;
    logic       unusedBits;

    assign sel    = (iAddress[31:5] == BASE_ADDR[31:5]);
    assign offset = iAddress[4:2];
    assign wrEn   = iWriteEnable & sel & iByteEnable[0];
    assign wrByte = iWriteData[7:0];

    assign unusedBits = ^{iWriteData[31:8], iByteEnable[3:1], iAddress[1:0]};

    assign edgeDet    = irqSync2 & ~irqPrev;
    assign setBits    = (wrEn && offset == OFF_SET)     ? wrByte : 8'h00;
    assign clrPending = (wrEn && offset == OFF_PENDING) ? wrByte : 8'h00;
    assign clrOverrun = (wrEn && offset == OFF_OVERRUN) ? wrByte : 8'h00;

    // Level sources simply follow s2, so a W1C only sticks once the line is low.
    always_comb begin
        pendingNext = 8'h00;
        overrunNext = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mode[i]) begin
                pendingNext[i] = edgeDet[i] | setBits[i] | (pending[i] & ~clrPending[i]);
            end else begin
                pendingNext[i] = irqSync2[i] | setBits[i];
            end
            overrunNext[i] = (overrun[i] & ~clrOverrun[i])
                           | (mode[i] & edgeDet[i] & pending[i] & ~clrPending[i]);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            irqSync1 <= 8'h00;
            irqSync2 <= 8'h00;
            irqPrev  <= 8'h00;
            pending  <= 8'h00;
            overrun  <= 8'h00;
            enable   <= RESET_ENABLE;
            mode     <= RESET_MODE;
        end else begin
            irqSync1 <= iIRQ;
            irqSync2 <= irqSync1;
            irqPrev  <= irqSync2;
            pending  <= pendingNext;
            overrun  <= overrunNext;
            if (wrEn && offset == OFF_ENABLE) enable <= wrByte;
            if (wrEn && offset == OFF_MODE)   mode   <= wrByte;
        end
    end

    always_comb begin
        oReadData = 32'h0;
        if (iReadEnable && sel) begin
            case (offset)
                OFF_PENDING: oReadData = {24'h0, pending};
                OFF_ENABLE:  oReadData = {24'h0, enable};
                OFF_MODE:    oReadData = {24'h0, mode};
                OFF_RAW:     oReadData = {24'h0, irqSync2};
                OFF_OVERRUN: oReadData = {24'h0, overrun};
                default:     oReadData = 32'h0;
            endcase
        end
    end

    assign oPendingInterrupt = pending & enable;
    assign oIRQAny           = |oPendingInterrupt;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: hand-computed expectations checked with immediate assertions.
module tb_irq_pending_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_0100;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [7:0]  iIRQ;
    logic        iReadEnable, iWriteEnable;
    logic [3:0]  iByteEnable;
    logic [31:0] iAddress, iWriteData;
    logic [31:0] oReadData;
    logic [7:0]  oPendingInterrupt;
    logic        oIRQAny;

    int vectors = 0;
    int errors  = 0;

    irq_pending_ctrl dut (
        .iCLK(iCLK), .iRST(iRST), .iIRQ(iIRQ),
        .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
        .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
        .oReadData(oReadData), .oPendingInterrupt(oPendingInterrupt), .oIRQAny(oIRQAny)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        iAddress     = addr;
        iWriteData   = data;
        iByteEnable  = be;
        iWriteEnable = 1'b1;
        tick();
        iWriteEnable = 1'b0;
        iByteEnable  = 4'h0;
        iWriteData   = 32'h0;
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        iAddress    = addr;
        iReadEnable = 1'b1;
        #1;
        check(tag, oReadData, exp);
        iReadEnable = 1'b0;
    endtask

    task automatic pulseIrq(input logic [7:0] bits);
        iIRQ = bits;
        tick();
        iIRQ = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        iRST = 1'b0; iIRQ = 8'hFF;
        iReadEnable = 1'b0; iWriteEnable = 1'b0;
        iByteEnable = 4'h0; iAddress = 32'h0; iWriteData = 32'h0;

        // reset with all lines asserted
        tick(); tick();
        check("rst_pend_out", {24'h0, oPendingInterrupt}, 32'h0);
        check("rst_any", {31'h0, oIRQAny}, 32'h0);
        checkRead("rst_pending", BASE + 32'h00, 32'h0);
        checkRead("rst_mode", BASE + 32'h08, 32'h0000_00FF);
        checkRead("rst_enable", BASE + 32'h04, 32'h0);

        iIRQ = 8'h00; iRST = 1'b1;
        tick(); tick(); tick();
        checkRead("idle_pending", BASE + 32'h00, 32'h0);

        // edge latch on bit 0
        busWrite(BASE + 32'h04, 32'h01, 4'b0001);
        iIRQ = 8'h01;
        tick();
        iIRQ = 8'h00;
        check("edge_n", {24'h0, oPendingInterrupt}, 32'h0);
        tick();
        check("edge_n1", {24'h0, oPendingInterrupt}, 32'h0);
        tick();
        check("edge_n2", {24'h0, oPendingInterrupt}, 32'h01);
        check("edge_any", {31'h0, oIRQAny}, 32'h1);
        busWrite(BASE + 32'h00, 32'h01, 4'b0001);
        check("w1c_out", {24'h0, oPendingInterrupt}, 32'h0);
        tick(); tick(); tick();
        checkRead("w1c_stay", BASE + 32'h00, 32'h0);

        // level mode on bit 0
        busWrite(BASE + 32'h08, 32'hFE, 4'b0001);
        iIRQ = 8'h01;
        tick(); tick(); tick();
        checkRead("lvl_pending", BASE + 32'h00, 32'h01);
        busWrite(BASE + 32'h00, 32'h01, 4'b0001);
        checkRead("lvl_w1c_ineff", BASE + 32'h00, 32'h01);
        checkRead("lvl_raw", BASE + 32'h0C, 32'h01);
        iIRQ = 8'h00;
        tick(); tick();
        checkRead("lvl_drop_n1", BASE + 32'h00, 32'h01);
        tick();
        checkRead("lvl_drop_n2", BASE + 32'h00, 32'h00);
        busWrite(BASE + 32'h08, 32'hFF, 4'b0001);

        // overrun on bit 3 (ENABLE still 0x01, so bit 3 is masked at the output)
        pulseIrq(8'h08);
        checkRead("ovr_first", BASE + 32'h00, 32'h08);
        check("ovr_masked", {24'h0, oPendingInterrupt}, 32'h0);
        checkRead("ovr_none", BASE + 32'h14, 32'h0);
        pulseIrq(8'h08);
        checkRead("ovr_set", BASE + 32'h14, 32'h08);
        checkRead("ovr_pend", BASE + 32'h00, 32'h08);
        // edge coincides with W1C of bit 3
        iIRQ = 8'h08;
        tick();
        iIRQ = 8'h00;
        tick();
        busWrite(BASE + 32'h00, 32'h08, 4'b0001);
        checkRead("coll_pend", BASE + 32'h00, 32'h08);
        checkRead("coll_ovr", BASE + 32'h14, 32'h08);
        busWrite(BASE + 32'h14, 32'h08, 4'b0001);
        checkRead("ovr_w1c", BASE + 32'h14, 32'h0);
        busWrite(BASE + 32'h00, 32'h08, 4'b0001);
        checkRead("ovr_pend_clr", BASE + 32'h00, 32'h0);

        // bus decode
        busWrite(BASE + 32'h10, 32'h0F, 4'b0010);
        checkRead("be_lane1", BASE + 32'h00, 32'h0);
        busWrite(BASE + 32'h10, 32'hFFFF_FF0F, 4'b0001);
        checkRead("be_lane0", BASE + 32'h00, 32'h0F);
        checkRead("set_reads0", BASE + 32'h10, 32'h0);
        checkRead("reserved", BASE + 32'h18, 32'h0);
        busWrite(BASE + 32'h20, 32'hFF, 4'b0001);
        checkRead("oob_read", BASE + 32'h20, 32'h0);
        checkRead("oob_nowrite", BASE + 32'h04, 32'h01);
        iAddress = BASE + 32'h00;
        #1;
        check("no_rden", oReadData, 32'h0);
        busWrite(BASE + 32'h0C, 32'hFF, 4'b0001);
        checkRead("raw_ro", BASE + 32'h0C, 32'h0);

        // mid-operation reset with an edge in flight
        busWrite(BASE + 32'h00, 32'hFF, 4'b0001);
        busWrite(BASE + 32'h10, 32'hA5, 4'b0001);
        busWrite(BASE + 32'h04, 32'hFF, 4'b0001);
        check("pre_rst_out", {24'h0, oPendingInterrupt}, 32'hA5);
        iIRQ = 8'h02;
        tick();
        iRST = 1'b0;
        tick();
        iRST = 1'b1;
        check("mid_rst_out", {24'h0, oPendingInterrupt}, 32'h0);
        checkRead("mid_rst_en", BASE + 32'h04, 32'h0);
        checkRead("mid_rst_mode", BASE + 32'h08, 32'hFF);
        iIRQ = 8'h00;
        tick(); tick(); tick();
        checkRead("mid_rst_lost", BASE + 32'h00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
